vx_mem_req_sched: RTL
=====================

# vx_mem_req_sched

Round-robin scheduler that shares one cache-line memory port among NUM_INPUTS requesters, such as several cache instances or bypass paths feeding a single memory port. It registers the granted request and prefixes its tag with the source index. Responses are routed back by that prefix. Per-input read credit counters cap outstanding reads so one requester cannot monopolise the response path.

## Interface
- NUM_INPUTS, 4, number of requesters (≥1)
- ADDR_WIDTH, 26, line address width
- DATA_WIDTH, 512, line data width (multiple of 8)
- TAG_IN_WIDTH, 8, requester tag width
- MAX_PENDING, 8, max outstanding reads per input (≥1)
- SEL_WIDTH (derived), max(1, clog2(NUM_INPUTS)); CNT_WIDTH (derived), clog2(MAX_PENDING+1)

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-low (asserted at 0)
- in_req_valid  in  NUM_INPUTS  per-input request valid
- in_req_rw  in  NUM_INPUTS  1 = write, 0 = read
- in_req_addr  in  NUM_INPUTS*ADDR_WIDTH  packed addresses
- in_req_data  in  NUM_INPUTS*DATA_WIDTH  packed write data
- in_req_byteen  in  NUM_INPUTS*DATA_WIDTH/8  packed byte enables
- in_req_tag  in  NUM_INPUTS*TAG_IN_WIDTH  packed tags
- in_req_ready  out  NUM_INPUTS  one-hot grant
- in_rsp_valid  out  NUM_INPUTS  per-input response valid
- in_rsp_data  out  DATA_WIDTH  shared response data
- in_rsp_tag  out  TAG_IN_WIDTH  response tag with prefix stripped
- in_rsp_ready  in  NUM_INPUTS  per-input response ready
- out_req_valid, out_req_rw  out  1  memory request valid and rw
- out_req_addr / out_req_data / out_req_byteen  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  request payload
- out_req_tag  out  SEL_WIDTH+TAG_IN_WIDTH  {source index, requester tag}
- out_req_ready  in  1  memory accepts request
- out_rsp_valid  in  1  memory response valid
- out_rsp_data  in  DATA_WIDTH  response data
- out_rsp_tag  in  SEL_WIDTH+TAG_IN_WIDTH  response tag
- out_rsp_ready  out  1  response accepted
- perf_stalls, perf_credit_stalls  out  PERF_CTR_BITS each  present only with the macro (see Configuration)

## Operation
- Eligibility:
  - eligible[i] = in_req_valid[i] && (in_req_rw[i] || pending[i] < MAX_PENDING).
  - Writes never consume credit and return no response.
- can_accept = !out_req_valid || out_req_ready.
- Grant:
  - When can_accept and any input is eligible, grant the first eligible index searching from rr_ptr upward, wrapping.
  - in_req_ready is one-hot on the winner, else all 0.
  - On a grant, rr_ptr <= (winner+1) mod NUM_INPUTS. rr_ptr is unchanged with no grant.
- Output register (1 entry):
  - On a grant, it loads the winner's payload with tag = {winner, in_req_tag[winner]}.
  - It clears when out_req_ready is high and there is no new grant.
- Credits:
  - pending[i] +1 on a granted read of i.
  - pending[i] −1 on a response handshake with sel == i.
  - Both in the same cycle → unchanged.
  - A decrement at 0 holds at 0 and fires an assertion.
- Response routing (combinational):
  - sel = out_rsp_tag[MSB -: SEL_WIDTH].
  - in_rsp_valid[sel] = out_rsp_valid; out_rsp_ready = in_rsp_ready[sel].
  - in_rsp_data and in_rsp_tag are broadcast.
  - sel ≥ NUM_INPUTS: out_rsp_ready = 1, response dropped, assertion fires.
- Reset (asynchronous assert, synchronous release):
  - Outputs: out_req_valid=0, in_req_ready=0, in_rsp_valid=0, out_rsp_ready=0.
  - State: rr_ptr=0, all pending=0, perf counters=0.
  - A reset mid-operation discards the buffered request and all credits. Requesters and memory must be reset together.

## Timing
- Request latency: 1 cycle from in_req handshake to out_req_valid.
- Throughput: 1 request per cycle while out_req_ready stays high.
- out_req_* hold stable while out_req_valid && !out_req_ready.
- in_req_ready depends combinationally on in_req_valid, pending and out_req_ready. out_req_valid never depends on out_req_ready.
- Response path: 0-cycle combinational, no storage.
- A credit freed in cycle t is usable for a grant in cycle t+1.

## Configuration
- VX_MEM_SCHED_PERF_EN
  - Defined: perf ports exist.
    - perf_stalls counts cycles with any in_req_valid and no grant.
    - perf_credit_stalls counts cycles where some input is valid, is a read, and is blocked only by credit.
    - Both counters are saturating.
  - Undefined: perf ports and counters are absent. Functional behaviour is identical.

## Structure
- VX_gpu_pkg holds:
  - the sched_perf_t struct {stalls, credit_stalls}
  - the SCHED_SEL_WIDTH(n) macro, max(1, clog2(n))
- One sub-module, vx_rr_pick: combinational find-first-from-pointer. Inputs: eligible mask, rr_ptr. Outputs: one-hot grant, index, any.

## Test plan
- Inputs 0–3 request reads continuously with out_req_ready=1 → grants 0,1,2,3,0 on consecutive cycles; out_req_tag prefix matches each grant.
- Input 1 issues 8 reads with no responses, MAX_PENDING=8 → 9th read blocked (in_req_ready[1]=0). One response with tag prefix 1 → read granted the next cycle.
- out_req_ready=0 for 5 cycles with a buffered write → payload stable, no grants. On release, the next request appears 1 cycle later.
- Response tag prefix 2 arrives while in_rsp_ready[2]=0 → out_rsp_ready=0; pending[2] unchanged until the handshake.
- Simultaneous granted read and response on input 0 at pending=3 → pending stays 3.
- reset=0 asserted mid-stream with out_req_valid=1 → out_req_valid=0 immediately (async); after release, first grant goes to input 0.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared types and helpers for the memory request scheduler.
// SCHED_SEL_WIDTH(n) gives the source-index width: max(1, clog2(n)).
`ifndef VX_GPU_PKG_SCHED_MACROS
`define VX_GPU_PKG_SCHED_MACROS
`define SCHED_SEL_WIDTH(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package VX_gpu_pkg;

  localparam int PERF_CTR_BITS = 32;

  typedef struct packed {
    logic [PERF_CTR_BITS-1:0] stalls;
    logic [PERF_CTR_BITS-1:0] credit_stalls;
  } sched_perf_t;

endpackage

// File: rtl/vx_mem_req_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above
// rr_ptr, wrapping around. Returns one-hot grant, its index and an any flag.
module vx_rr_pick #(
  parameter int NUM_INPUTS = 4,
  localparam int SEL_WIDTH = `SCHED_SEL_WIDTH(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] eligible,
  input  logic [SEL_WIDTH-1:0]  rr_ptr,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [SEL_WIDTH-1:0]  idx,
  output logic                  any
);

  logic [SEL_WIDTH:0]   sum;
  logic [SEL_WIDTH-1:0] cand;

  // NOTE: every output and temporary gets a default before the loop, so no
  // path through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      // rr_ptr < NUM_INPUTS and k < NUM_INPUTS, so one subtraction wraps
      sum  = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
      cand = (sum >= (SEL_WIDTH+1)'(NUM_INPUTS)) ?
             SEL_WIDTH'(sum - (SEL_WIDTH+1)'(NUM_INPUTS)) : sum[SEL_WIDTH-1:0];
      if (!any && eligible[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_mem_req_sched.sv
// Round-robin scheduler sharing one memory port among NUM_INPUTS requesters,
// with per-input read credits. Optional perf counters: VX_MEM_SCHED_PERF_EN.
module vx_mem_req_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS   = 4,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_IN_WIDTH = 8,
  parameter int MAX_PENDING  = 8,
  localparam int SEL_WIDTH     = `SCHED_SEL_WIDTH(NUM_INPUTS),
  localparam int CNT_WIDTH     = $clog2(MAX_PENDING + 1),
  localparam int TAG_OUT_WIDTH = SEL_WIDTH + TAG_IN_WIDTH,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic [NUM_INPUTS-1:0]              in_req_valid,
  input  logic [NUM_INPUTS-1:0]              in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_INPUTS*BYTEEN_WIDTH-1:0] in_req_byteen,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_INPUTS-1:0]              in_req_ready,

  output logic [NUM_INPUTS-1:0]              in_rsp_valid,
  output logic [DATA_WIDTH-1:0]              in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]            in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]              in_rsp_ready,

  output logic                               out_req_valid,
  output logic                               out_req_rw,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [DATA_WIDTH-1:0]              out_req_data,
  output logic [BYTEEN_WIDTH-1:0]            out_req_byteen,
  output logic [TAG_OUT_WIDTH-1:0]           out_req_tag,
  input  logic                               out_req_ready,

  input  logic                               out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              out_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]           out_rsp_tag,
  output logic                               out_rsp_ready
`ifdef VX_MEM_SCHED_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]           perf_stalls,
  output logic [PERF_CTR_BITS-1:0]           perf_credit_stalls
`endif
);

  logic [NUM_INPUTS-1:0] credit_ok;
  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] pick_grant;
  logic [NUM_INPUTS-1:0] credit_inc;
  logic [NUM_INPUTS-1:0] credit_dec;
  logic [SEL_WIDTH-1:0]  pick_idx;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  rsp_sel;
  logic                  pick_any;
  logic                  can_accept;
  logic                  grant_any;
  logic                  rsp_sel_ok;
  logic                  rsp_fire;
  logic [CNT_WIDTH-1:0]  pending [NUM_INPUTS];

  // ---------------------------------------------------------------- grant
  always_comb begin
    credit_ok = '0;
    eligible  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      credit_ok[i] = pending[i] < CNT_WIDTH'(MAX_PENDING);
      eligible[i]  = in_req_valid[i] && (in_req_rw[i] || credit_ok[i]);
    end
  end

  assign can_accept = !out_req_valid || out_req_ready;

  // Masking with reset keeps in_req_ready low while reset is asserted.
  vx_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_rr_pick (
    .eligible (eligible & {NUM_INPUTS{can_accept && reset}}),
    .rr_ptr   (rr_ptr),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign grant_any    = pick_any;
  assign in_req_ready = pick_grant;

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (pick_idx == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // ------------------------------------------------------- output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_req_valid <= 1'b0;
    end else if (grant_any) begin
      out_req_valid <= 1'b1;
    end else if (out_req_ready) begin
      out_req_valid <= 1'b0;
    end
  end

  // NOTE: the payload flops are deliberately left without reset; they are
  // only meaningful while out_req_valid, which is reset.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      out_req_rw     <= in_req_rw[pick_idx];
      out_req_addr   <= in_req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      out_req_data   <= in_req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_req_byteen <= in_req_byteen[int'(pick_idx)*BYTEEN_WIDTH +: BYTEEN_WIDTH];
      out_req_tag    <= {pick_idx, in_req_tag[int'(pick_idx)*TAG_IN_WIDTH +: TAG_IN_WIDTH]};
    end
  end

  // ------------------------------------------------------- response routing
  assign rsp_sel    = out_rsp_tag[TAG_OUT_WIDTH-1 -: SEL_WIDTH];
  assign rsp_sel_ok = {1'b0, rsp_sel} < (SEL_WIDTH+1)'(NUM_INPUTS);
  assign in_rsp_data = out_rsp_data;
  assign in_rsp_tag  = out_rsp_tag[TAG_IN_WIDTH-1:0];

  always_comb begin
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b0;
    if (reset) begin
      if (rsp_sel_ok) begin
        in_rsp_valid[rsp_sel] = out_rsp_valid;
        out_rsp_ready         = in_rsp_ready[rsp_sel];
      end else begin
        // Unroutable responses are drained so the memory side never wedges.
        out_rsp_ready = 1'b1;
      end
    end
  end

  assign rsp_fire = out_rsp_valid && out_rsp_ready && rsp_sel_ok;

  // ---------------------------------------------------------------- credits
  always_comb begin
    credit_inc = '0;
    credit_dec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      credit_inc[i] = grant_any && pick_grant[i] && !in_req_rw[i];
      credit_dec[i] = rsp_fire && (rsp_sel == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (credit_inc[i] && !credit_dec[i]) begin
          pending[i] <= pending[i] + 1'b1;
        end else if (credit_dec[i] && !credit_inc[i] && pending[i] != '0) begin
          pending[i] <= pending[i] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_credit_chk
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(credit_dec[g] && !credit_inc[g] && pending[g] == '0));
  end

  a_rsp_routable: assert property (@(posedge clk) disable iff (!reset)
    !(out_rsp_valid && !rsp_sel_ok));

  // ------------------------------------------------------------ perf counters
`ifdef VX_MEM_SCHED_PERF_EN
  sched_perf_t perf_q;
  logic        stall_cyc;
  logic        credit_stall_cyc;

  assign stall_cyc        = (|in_req_valid) && !grant_any;
  assign credit_stall_cyc = |(in_req_valid & ~in_req_rw & ~credit_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      if (stall_cyc && !(&perf_q.stalls)) begin
        perf_q.stalls <= perf_q.stalls + 1'b1;
      end
      if (credit_stall_cyc && !(&perf_q.credit_stalls)) begin
        perf_q.credit_stalls <= perf_q.credit_stalls + 1'b1;
      end
    end
  end

  assign perf_stalls        = perf_q.stalls;
  assign perf_credit_stalls = perf_q.credit_stalls;
`endif

endmodule
